// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch button conditioner: debounce state
// encoding, default debounce timing and the bit index of each raw input.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } db_state_e;

  // 5 ms of stable samples at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  // 2**20 > 500000, so the counter can hold the full debounce window
  localparam int CNT_W_DEF = 20;

  localparam int BTN_L  = 0;
  localparam int BTN_R  = 1;
  localparam int SW_ADJ = 2;
  localparam int NUM_IN = 3;

endpackage

// File: rtl/debounce.sv
// Single-input conditioner: 2-flop synchronizer, 4-state debounce FSM with a
// stable-sample counter, debounced level and a one-cycle rise pulse.
// rise_d_o is the combinational value rise_o will take on the next edge, so
// a parent can react on the same edge that registers the pulse.
// Handshake: none; raw_i is a free-running asynchronous level.
module debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      raw_i,
  output logic      level_o,
  output logic      rise_o,
  output logic      rise_d_o,
  output db_state_e state_o
);

  // Last count value of the stable window; CNT_W must satisfy 2**CNT_W > DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             rise_d;

  // Accept a press on the final stable sample of the rising window.
  assign rise_d = (state_q == WAIT_HI) && sync2_q && (cnt_q == CNT_LAST);

  // Two-flop synchronizer for the asynchronous raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM with counter, registered level and registered rise pulse.
  // The counter only advances below CNT_LAST and is cleared on every state
  // change, so it saturates by construction and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      rise_q <= rise_d;
      case (state_q)
        LOW: begin
          if (sync2_q) begin
            state_q <= WAIT_HI;
            cnt_q   <= '0;
          end
        end
        WAIT_HI: begin
          if (!sync2_q) begin
            state_q <= LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HIGH;
            cnt_q   <= '0;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!sync2_q) begin
            state_q <= WAIT_LO;
            cnt_q   <= '0;
          end
        end
        WAIT_LO: begin
          if (sync2_q) begin
            state_q <= HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= LOW;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_o  = level_q;
  assign rise_o   = rise_q;
  assign rise_d_o = rise_d;
  assign state_o  = state_q;

endmodule

// File: rtl/button_cond.sv
// Stopwatch button conditioner: debounces the pause/run button, the clear
// button and the adjust switch, then turns the pause button into a run/stop
// toggle and the clear button into a single-cycle clear pulse.
// Optional feature macro: CLR_PAUSES_EN -- when defined, a clear pulse also
// forces the stopwatch into the stopped state, overriding a simultaneous
// pause toggle.
module button_cond
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       adj_sw,
  output logic       pause,
  output logic       clr,
  output logic       adj,
  output logic [2:0] btn_lvl
);

  logic [NUM_IN-1:0] raw;
  logic [NUM_IN-1:0] level;
  logic [NUM_IN-1:0] rise_q;
  logic [NUM_IN-1:0] rise_d;
  db_state_e         db_state [NUM_IN];
  logic              pause_q;

  assign raw[BTN_L]  = btnL;
  assign raw[BTN_R]  = btnR;
  assign raw[SW_ADJ] = adj_sw;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_db
    debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (raw[g]),
      .level_o  (level[g]),
      .rise_o   (rise_q[g]),
      .rise_d_o (rise_d[g]),
      .state_o  (db_state[g])
    );
  end

  // Run/stop toggle, updated on the same edge that registers the btnL pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_q <= 1'b0;
    end else begin
`ifdef CLR_PAUSES_EN
      if (rise_d[BTN_R]) begin
        pause_q <= 1'b1;
      end else if (rise_d[BTN_L]) begin
        pause_q <= ~pause_q;
      end
`else
      if (rise_d[BTN_L]) begin
        pause_q <= ~pause_q;
      end
`endif
    end
  end

  assign pause   = pause_q;
  assign clr     = rise_q[BTN_R];
  assign adj     = level[SW_ADJ];
  assign btn_lvl = level;

  // Per-input state and pulse bits not needed by the output logic; kept
  // visible on the debounce instances for observation.
  logic unused_dbg;
  assign unused_dbg = ^{rise_q, rise_d, db_state[BTN_L], db_state[BTN_R], db_state[SW_ADJ]};

endmodule

// File: doc/button_cond.md
BUTTON_COND -- requirements
Module: button_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable synchronized samples needed to accept a level change (5 ms at 100 MHz).
REQ-002 Parameter CNT_W, default 20, is the debounce counter width; it SHALL satisfy 2**CNT_W > DEBOUNCE_CYCLES.
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 btnL  input  1  raw pause/run button, asynchronous, bouncy.
REQ-006 btnR  input  1  raw clear button, asynchronous, bouncy.
REQ-007 adj_sw  input  1  raw adjust-mode switch, asynchronous, bouncy.
REQ-008 pause  output  1  run/stop state for the counter; 1 = stopped.
REQ-009 clr  output  1  single-cycle clear pulse for the counter.
REQ-010 adj  output  1  debounced adjust level.
REQ-011 btn_lvl  output  3  debounced levels {adj_sw, btnR, btnL}, for observation.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each input SHALL have a 4-state debounce FSM: LOW, WAIT_HI, HIGH, WAIT_LO.
REQ-014 LOW: if sync=1, go to WAIT_HI and load count=0; otherwise stay.
REQ-015 WAIT_HI: sync=0 returns to LOW (glitch rejected); sync=1 increments count; when count reaches DEBOUNCE_CYCLES-1 with sync=1, go to HIGH.
REQ-016 HIGH and WAIT_LO SHALL mirror LOW and WAIT_HI with polarity inverted.
REQ-017 The debounced level SHALL be 1 in HIGH and WAIT_LO, and 0 in LOW and WAIT_HI.
REQ-018 A rise pulse (1 cycle) SHALL assert in the first cycle the level is 1, i.e. registered on the WAIT_HI->HIGH transition.
REQ-019 Latency from the first clk edge sampling a stable raw high to the rise pulse SHALL be DEBOUNCE_CYCLES+2 cycles.
REQ-020 A btnL rise SHALL toggle pause on the same edge the pulse is registered; a release SHALL have no effect.
REQ-021 clr SHALL equal the btnR rise pulse: exactly one cycle per accepted press, regardless of hold time.
REQ-022 adj SHALL equal the adj_sw debounced level; no pulse is generated for it.
REQ-023 Simultaneous btnL and btnR rises in one cycle SHALL both take effect: pause toggles and clr asserts.
REQ-024 The counter SHALL saturate and never wrap; a held input stays in HIGH with no further pulses.

Reset
REQ-025 rst_n low SHALL immediately force, asynchronously:
- synchronizers to 0
- FSMs to LOW, counts to 0
- pause=0, clr=0, adj=0, btn_lvl=0
REQ-026 A button held through reset release SHALL be treated as a new press, producing one pulse after the full debounce latency.
REQ-027 Reset asserted mid-debounce SHALL discard partial counts, with no pulse.

Configuration
REQ-028 With CLR_PAUSES_EN defined, a clr pulse SHALL also force pause=1 on the same edge, overriding a simultaneous btnL toggle.
REQ-029 Without CLR_PAUSES_EN, clr SHALL leave pause unchanged, and REQ-023 applies.

Structure
REQ-030 A shared package stopwatch_pkg SHALL hold:
- the debounce state enum (LOW, WAIT_HI, HIGH, WAIT_LO)
- the DEBOUNCE_CYCLES default
- the input bit indices (BTN_L=0, BTN_R=1, SW_ADJ=2)
REQ-031 One sub-module debounce SHALL contain the synchronizer, FSM, counter, level and rise pulse; it is instantiated three times.
REQ-032 The pause toggle and clr logic SHALL live in button_cond.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 btnL held high for 20 cycles -> exactly one btnL rise 6 cycles after the first sampling edge; pause 0->1; held input produces no further pulses.
REQ-034 btnR bouncing 1,0,1,0 every cycle, then stable high -> no clr during the bounce; one clr exactly 6 cycles after stable high begins.
REQ-035 btnL pressed twice with full release between presses -> pause 0->1->0; each press yields one pulse.
REQ-036 btnL and btnR rising in the same cycle -> clr=1 that cycle; pause toggles without CLR_PAUSES_EN and ends at 1 with it.
REQ-037 rst_n pulsed low at count=2 of a btnR press -> all outputs 0 immediately; held btnR gives one clr 6 cycles after rst_n rises.
REQ-038 adj_sw with a 2-cycle glitch -> adj stays 0; a stable high raises adj after 6 cycles and never produces clr or a pause change.
